parity_stream: RTL and testbench
================================

# parity_stream

Parametrised, pipelined parity unit for streaming data words. Generates per-word parity (generate mode) or checks received parity (check mode), with even/odd selection, a valid/ready handshake on both sides, a saturating error counter, and a per-frame longitudinal parity (LRC) word. It sits on any byte/word stream between a producer and a consumer and replaces fixed 3-input parity logic.

## Interface
- DATA_W, 8, data word width in bits (>= 2)
- ODD, 0, 0 = even parity (XOR of data and parity bit = 0); 1 = odd parity (XOR = 1)
- CNT_W, 8, error counter width (>= 2)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = generate, 1 = check; sampled with each accepted word
- clr_cnt  in  1  synchronous clear of err_cnt
- in_valid  in  1  input word valid
- in_ready  out  1  unit can accept a word
- in_data  in  DATA_W  input word
- in_par  in  1  received parity bit (check mode only; ignored in generate mode)
- in_last  in  1  marks the last word of a frame
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the output word
- out_data  out  DATA_W  registered copy of in_data
- out_par  out  1  computed parity bit for out_data
- out_err  out  1  check mode: received parity mismatched; always 0 in generate mode
- out_last  out  1  registered in_last
- out_lrc  out  DATA_W  bitwise XOR of all data words in the frame, including this one; meaningful only when out_last = 1
- err_cnt  out  CNT_W  count of parity errors detected, saturating

## Operation
- Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
- in_ready = !out_valid | out_ready (single output register stage, combinational ready passthrough).
- Accepted word: out_data <= in_data; out_last <= in_last; out_par <= ^in_data ^ ODD.
- Check mode: out_err <= (^in_data ^ in_par) != ODD. Generate mode: out_err <= 0.
- LRC accumulator acc (DATA_W bits, internal): on each accepted word, out_lrc <= acc ^ in_data; acc <= in_last ? 0 : acc ^ in_data. A single-word frame (first word with in_last = 1) gives out_lrc = in_data.
- out_lrc holds the running XOR on non-last words; consumers use it only when out_last = 1.
- err_cnt increments by 1 on each accepted word whose computed err is 1; holds at 2^CNT_W - 1 (no wrap).
- clr_cnt has priority over increment: the counter goes to 0 even if an error word is accepted in the same cycle.
- mode may change between words without flushing; each word uses the mode sampled at its acceptance.
- Output regs hold stable while out_valid & !out_ready (no data change under backpressure).
- out_valid <= 1 on input accept; else out_valid <= 0 on output transfer with no new accept; else hold.

## Timing
- Latency: 1 cycle, input accept to out_valid.
- Throughput: 1 word/cycle with out_ready held high; simultaneous output transfer and input accept in the same cycle refills the register with no bubble.
- Backpressure: out_ready = 0 with out_valid = 1 forces in_ready = 0 in that cycle.
- Reset (async assert, released sync to clk): out_valid = 0, out_data = 0, out_par = 0, out_err = 0, out_last = 0, out_lrc = 0, acc = 0, err_cnt = 0. in_ready = 1 after reset.
- Reset mid-frame: the partial LRC is discarded, and the next accepted word starts a new frame.
- No combinational path from in_valid to out_valid; in_ready depends combinationally only on out_valid and out_ready.

## Test plan
- Generate, even, DATA_W=8: words 0x00, 0x01, 0xFF, 0x7F with out_ready = 1 -> out_par = 0, 1, 0, 1, each 1 cycle after accept; out_err = 0; err_cnt = 0.
- Check, ODD=1: in_data = 0x03 with in_par = 1 -> out_err = 0. in_data = 0x03 with in_par = 0 -> out_err = 1 and err_cnt 0 -> 1.
- LRC frame: words 0x12, 0x34, 0x56 with in_last on the third -> out_lrc = 0x70 with out_last = 1. Next single-word frame 0xA5 with in_last = 1 -> out_lrc = 0xA5.
- Backpressure: stream 4 words with out_ready toggling 1,0,0,1,... -> no word lost or duplicated, out_data stable while stalled, in_ready = 0 whenever out_valid & !out_ready.
- Counter: CNT_W=2, 5 consecutive bad-parity words -> err_cnt 1, 2, 3, 3, 3. Then clr_cnt together with a bad word -> err_cnt = 0.
- Reset mid-frame: assert rst_n low after 2 words of a frame -> all outputs 0 immediately. After release, 0x0F with in_last -> out_lrc = 0x0F.

Source files
------------

// File: rtl/parity_stream_if.sv
// rtl/parity_stream_if.sv - input/output stream bundle for parity_stream
interface parity_stream_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_par;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_par;
   logic              out_err;
   logic              out_last;
   logic [DATA_W-1:0] out_lrc;

   modport master (
      output in_valid, in_data, in_par, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_par, out_err, out_last, out_lrc
   );

   modport slave (
      input  in_valid, in_data, in_par, in_last, out_ready,
      output in_ready, out_valid, out_data, out_par, out_err, out_last, out_lrc
   );
endinterface

// File: rtl/parity_stream.sv
// rtl/parity_stream.sv - single-stage parity generate/check with frame LRC
// and a saturating error counter.
module parity_stream #(
   parameter int DATA_W = 8,
   parameter int ODD    = 0,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] err_cnt,
   parity_stream_if.slave   s
);
   localparam logic             ODD_B   = (ODD != 0);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_par_q,   out_par_d;
   logic              out_err_q,   out_err_d;
   logic              out_last_q,  out_last_d;
   logic [DATA_W-1:0] out_lrc_q,   out_lrc_d;
   logic [DATA_W-1:0] acc_q,       acc_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;

   logic              in_accept;
   logic              out_xfer;
   logic              par_calc;
   logic              err_calc;

   // Ready depends only on the output register, never on in_valid.
   assign s.in_ready = !out_valid_q || s.out_ready;
   assign in_accept  = s.in_valid && s.in_ready;
   assign out_xfer   = out_valid_q && s.out_ready;
   assign par_calc   = (^s.in_data) ^ ODD_B;
   assign err_calc   = mode && (((^s.in_data) ^ s.in_par) != ODD_B);

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_par_d   = out_par_q;
      out_err_d   = out_err_q;
      out_last_d  = out_last_q;
      out_lrc_d   = out_lrc_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;

      if (in_accept) begin
         out_valid_d = 1'b1;
         out_data_d  = s.in_data;
         out_par_d   = par_calc;
         out_err_d   = err_calc;
         out_last_d  = s.in_last;
         out_lrc_d   = acc_q ^ s.in_data;
         acc_d       = s.in_last ? '0 : (acc_q ^ s.in_data);
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
      end

      // Clear wins over a simultaneous error increment.
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (in_accept && err_calc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_par_q   <= 1'b0;
         out_err_q   <= 1'b0;
         out_last_q  <= 1'b0;
         out_lrc_q   <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_par_q   <= out_par_d;
         out_err_q   <= out_err_d;
         out_last_q  <= out_last_d;
         out_lrc_q   <= out_lrc_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign s.out_valid = out_valid_q;
   assign s.out_data  = out_data_q;
   assign s.out_par   = out_par_q;
   assign s.out_err   = out_err_q;
   assign s.out_last  = out_last_q;
   assign s.out_lrc   = out_lrc_q;
   assign err_cnt     = cnt_q;
endmodule

// File: tb/tb_parity_stream.sv
// tb/tb_parity_stream.sv - directed bench: even/8-bit counter unit (a) and
// odd/2-bit counter unit (b) fed the same stream.
module tb_parity_stream;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mode = 1'b0;
   logic       clr_cnt = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_par = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   parity_stream_if #(.DATA_W(8)) ia ();
   parity_stream_if #(.DATA_W(8)) ib ();

   assign ia.in_valid  = in_valid;
   assign ia.in_data   = in_data;
   assign ia.in_par    = in_par;
   assign ia.in_last   = in_last;
   assign ia.out_ready = out_ready;
   assign ib.in_valid  = in_valid;
   assign ib.in_data   = in_data;
   assign ib.in_par    = in_par;
   assign ib.in_last   = in_last;
   assign ib.out_ready = out_ready;

   parity_stream #(.DATA_W(8), .ODD(0), .CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .mode(mode), .clr_cnt(clr_cnt),
      .err_cnt(cnt_a), .s(ia.slave)
   );
   parity_stream #(.DATA_W(8), .ODD(1), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .mode(mode), .clr_cnt(clr_cnt),
      .err_cnt(cnt_b), .s(ib.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic p, input logic l, input logic m);
      in_data  = d;
      in_par   = p;
      in_last  = l;
      mode     = m;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] d, input logic pa, input logic pb,
                          input logic ea, input logic eb, input logic l, input logic [7:0] lrc);
      chk({tag, " a.valid"}, ia.out_valid, 1'b1);
      chk({tag, " a.data"},  ia.out_data,  d);
      chk({tag, " a.par"},   ia.out_par,   pa);
      chk({tag, " b.par"},   ib.out_par,   pb);
      chk({tag, " a.err"},   ia.out_err,   ea);
      chk({tag, " b.err"},   ib.out_err,   eb);
      chk({tag, " a.last"},  ia.out_last,  l);
      chk({tag, " a.lrc"},   ia.out_lrc,   lrc);
      chk({tag, " b.lrc"},   ib.out_lrc,   lrc);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " a.valid"}, ia.out_valid, 1'b0);
      chk({tag, " b.valid"}, ib.out_valid, 1'b0);
      chk({tag, " a.data"},  ia.out_data,  8'h00);
      chk({tag, " b.par"},   ib.out_par,   1'b0);
      chk({tag, " a.par"},   ia.out_par,   1'b0);
      chk({tag, " b.err"},   ib.out_err,   1'b0);
      chk({tag, " a.last"},  ia.out_last,  1'b0);
      chk({tag, " a.lrc"},   ia.out_lrc,   8'h00);
      chk({tag, " cnt_a"},   cnt_a,        8'd0);
      chk({tag, " cnt_b"},   cnt_b,        2'd0);
      chk({tag, " a.ready"}, ia.in_ready,  1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bp_words [5];
      logic [7:0] mdata;
      logic       mvalid;
      logic       exp_ready;
      int         sent;
      int         got;
      int         cyc;
      bp_words[0] = 8'hA5; bp_words[1] = 8'h11; bp_words[2] = 8'h22;
      bp_words[3] = 8'h33; bp_words[4] = 8'h44;

      #12;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // generate mode, even (a) / odd (b)
      send(8'h00, 1'b0, 1'b0, 1'b0); chk_out("gen00", 8'h00, 0, 1, 0, 0, 0, 8'h00);
      send(8'h01, 1'b0, 1'b0, 1'b0); chk_out("gen01", 8'h01, 1, 0, 0, 0, 0, 8'h01);
      send(8'hFF, 1'b0, 1'b0, 1'b0); chk_out("genFF", 8'hFF, 0, 1, 0, 0, 0, 8'hFE);
      send(8'h7F, 1'b0, 1'b1, 1'b0); chk_out("gen7F", 8'h7F, 1, 0, 0, 0, 1, 8'h81);
      chk("gen cnt_a", cnt_a, 8'd0);
      chk("gen cnt_b", cnt_b, 2'd0);

      // check mode
      send(8'h03, 1'b1, 1'b1, 1'b1); chk_out("chk03p1", 8'h03, 0, 1, 1, 0, 1, 8'h03);
      chk("chk03p1 cnt_a", cnt_a, 8'd1);
      chk("chk03p1 cnt_b", cnt_b, 2'd0);
      send(8'h03, 1'b0, 1'b1, 1'b1); chk_out("chk03p0", 8'h03, 0, 1, 0, 1, 1, 8'h03);
      chk("chk03p0 cnt_a", cnt_a, 8'd1);
      chk("chk03p0 cnt_b", cnt_b, 2'd1);

      // LRC frame then single-word frame
      send(8'h12, 1'b0, 1'b0, 1'b0); chk_out("lrc12", 8'h12, 0, 1, 0, 0, 0, 8'h12);
      send(8'h34, 1'b0, 1'b0, 1'b0); chk_out("lrc34", 8'h34, 1, 0, 0, 0, 0, 8'h26);
      send(8'h56, 1'b0, 1'b1, 1'b0); chk_out("lrc56", 8'h56, 0, 1, 0, 0, 1, 8'h70);
      send(8'hA5, 1'b0, 1'b1, 1'b0); chk_out("lrcA5", 8'hA5, 0, 1, 0, 0, 1, 8'hA5);

      // backpressure: out_ready pattern 1,0,0,1; A5 still sits in the output register
      mvalid = 1'b1;
      mdata  = 8'hA5;
      sent   = 1;
      got    = 0;
      cyc    = 0;
      mode   = 1'b0;
      while (got < 5 && cyc < 40) begin
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         in_valid  = (sent < 5);
         in_data   = bp_words[(sent < 5) ? sent : 4];
         in_last   = (sent == 4);
         #1;
         exp_ready = !mvalid || out_ready;
         chk("bp a.ready", ia.in_ready, exp_ready);
         chk("bp b.ready", ib.in_ready, exp_ready);
         chk("bp a.valid", ia.out_valid, mvalid);
         if (mvalid) chk("bp a.data", ia.out_data, mdata);
         if (mvalid && out_ready) begin
            chk("bp order", ia.out_data, bp_words[got]);
            if (got == 4) chk("bp lrc", ia.out_lrc, 8'h44);
            got++;
         end
         if (in_valid && exp_ready) begin
            mdata  = bp_words[sent];
            mvalid = 1'b1;
            sent++;
         end else if (mvalid && out_ready) begin
            mvalid = 1'b0;
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp all words out", got, 5);

      // saturating counter on b (CNT_W=2): 0x03 with par 0 is bad for odd only
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      chk("clr cnt_a", cnt_a, 8'd0);
      chk("clr cnt_b", cnt_b, 2'd0);
      for (int i = 0; i < 5; i++) begin
         send(8'h03, 1'b0, 1'b1, 1'b1);
         chk($sformatf("sat%0d b.err", i), ib.out_err, 1'b1);
         chk($sformatf("sat%0d a.err", i), ia.out_err, 1'b0);
         chk($sformatf("sat%0d cnt_b", i), cnt_b, (i < 3) ? i + 1 : 3);
         chk($sformatf("sat%0d cnt_a", i), cnt_a, 8'd0);
      end
      clr_cnt = 1'b1;
      send(8'h03, 1'b0, 1'b1, 1'b1);
      clr_cnt = 1'b0;
      chk("clr+err b.err", ib.out_err, 1'b1);
      chk("clr+err cnt_b", cnt_b, 2'd0);

      // reset mid-frame discards partial LRC
      send(8'hAA, 1'b0, 1'b0, 1'b0);
      send(8'h55, 1'b0, 1'b0, 1'b0);
      chk("mid lrc", ia.out_lrc, 8'hFF);
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      #3;
      rst_n = 1'b1;
      send(8'h0F, 1'b0, 1'b1, 1'b0); chk_out("post0F", 8'h0F, 0, 1, 0, 0, 1, 8'h0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
